// File: rtl/checker_arqui_multi.sv
// Clocked multi-channel checker: behavioural vs structural outputs.
// Tracks per-cycle result, sticky flags, a saturating count and the first failure.
module checker_arqui_multi #(
    parameter int NUM_CH        = 5,
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16,
    parameter int TIME_W        = 32,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    check_en,
    input  logic [NUM_CH-1:0]       ch_mask,
    input  logic                    clear_err,
    input  logic [NUM_CH*WIDTH-1:0] data_c,
    input  logic [NUM_CH*WIDTH-1:0] data_e,
    output logic                    checks_ok,
    output logic                    err_sticky,
    output logic [NUM_CH-1:0]       err_mask,
    output logic [CNT_W-1:0]        err_count,
    output logic [CH_W-1:0]         first_ch,
    output logic [TIME_W-1:0]       first_time,
    output logic [1:0]              state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_CHECK = 2'd2,
        ST_FAIL  = 2'd3
    } state_t;

    localparam logic [7:0]        SETTLE_L = 8'(SETTLE_CYCLES);
    localparam logic [TIME_W-1:0] T_ONE    = 1;
    localparam logic [CNT_W-1:0]  C_ONE    = 1;

    state_t              state_q, state_d;
    logic [7:0]          settle_q, settle_d;
    logic [TIME_W-1:0]   cyc_q, cyc_d;
    logic                checks_ok_q, checks_ok_d;
    logic                err_sticky_q, err_sticky_d;
    logic [NUM_CH-1:0]   err_mask_q, err_mask_d;
    logic [CNT_W-1:0]    err_count_q, err_count_d;
    logic [CH_W-1:0]     first_ch_q, first_ch_d;
    logic [TIME_W-1:0]   first_time_q, first_time_d;

    logic [NUM_CH-1:0]   neq;
    logic                any_neq;
    logic [CH_W-1:0]     low_idx;
    logic                first_hit;

    // Case inequality so X/Z on either side is reported as a mismatch.
    always_comb begin
        neq = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            neq[i] = ch_mask[i] &
                     (data_c[i*WIDTH +: WIDTH] !== data_e[i*WIDTH +: WIDTH]);
        end
    end

    assign any_neq = |neq;

    always_comb begin
        low_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (neq[i]) low_idx = CH_W'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        cyc_d        = cyc_q + T_ONE;
        checks_ok_d  = 1'b1;
        err_sticky_d = err_sticky_q;
        err_mask_d   = err_mask_q;
        err_count_d  = err_count_q;
        first_ch_d   = first_ch_q;
        first_time_d = first_time_q;
        first_hit    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (check_en) begin
                    state_d  = ST_ARM;
                    settle_d = SETTLE_L;
                end
            end
            ST_ARM: begin
                if (!check_en) begin
                    state_d = ST_IDLE;
                end else begin
                    if (settle_q <= 8'd1) state_d = ST_CHECK;
                    if (settle_q != 8'd0) settle_d = settle_q - 8'd1;
                end
            end
            ST_CHECK, ST_FAIL: begin
                if (!check_en) begin
                    state_d = ST_IDLE;
                end else begin
                    checks_ok_d = !any_neq;
                    if (clear_err) begin
                        state_d = ST_CHECK;
                    end else if (any_neq) begin
                        err_mask_d = err_mask_q | neq;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + C_ONE;
                        end
                        if (state_q == ST_CHECK) begin
                            first_hit    = 1'b1;
                            state_d      = ST_FAIL;
                            err_sticky_d = 1'b1;
                            first_ch_d   = low_idx;
                            first_time_d = cyc_q;
                        end
                    end
                end
            end
        endcase

        // Clear wins over any same-cycle mismatch; the count survives.
        if (clear_err) begin
            err_sticky_d = 1'b0;
            err_mask_d   = '0;
            first_ch_d   = '0;
            first_time_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            settle_q     <= '0;
            cyc_q        <= '0;
            checks_ok_q  <= 1'b1;
            err_sticky_q <= 1'b0;
            err_mask_q   <= '0;
            err_count_q  <= '0;
            first_ch_q   <= '0;
            first_time_q <= '0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            cyc_q        <= cyc_d;
            checks_ok_q  <= checks_ok_d;
            err_sticky_q <= err_sticky_d;
            err_mask_q   <= err_mask_d;
            err_count_q  <= err_count_d;
            first_ch_q   <= first_ch_d;
            first_time_q <= first_time_d;
`ifndef SYNTHESIS
            if (first_hit) begin
                $display("%0t checker_arqui_multi: first mismatch ch=%0d c=%h e=%h",
                         $time, low_idx,
                         data_c[low_idx*WIDTH +: WIDTH],
                         data_e[low_idx*WIDTH +: WIDTH]);
            end
`endif
        end
    end

    assign checks_ok  = checks_ok_q;
    assign err_sticky = err_sticky_q;
    assign err_mask   = err_mask_q;
    assign err_count  = err_count_q;
    assign first_ch   = first_ch_q;
    assign first_time = first_time_q;
    assign state      = state_q;

endmodule

// File: doc/checker_arqui_multi.md
Name: checker_arqui_multi

Overview:
- Parametrised, clocked successor to the single-shot behavioural-vs-structural checker.
- Compares NUM_CH channel pairs, each WIDTH bits: one side from the behavioural ("_c") model, the other from the synthesised ("_e") model.
- Registers per-cycle and sticky results, counts mismatches, and captures the first failing channel and cycle.
- Sits in the testbench next to the DUT pair; it is sequential testbench RTL, not synthesised into the design.

Parameters:
- NUM_CH, 5: number of compared channel pairs (1..32).
- WIDTH, 4: bits per channel; narrower signals are zero-extended by the instantiator.
- SETTLE_CYCLES, 2: cycles after check_en rises during which compares are ignored (0..255).
- CNT_W, 16: width of the mismatch counter.
- TIME_W, 32: width of the cycle timestamp.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- check_en  input  1  enables checking.
- ch_mask  input  NUM_CH  1 = channel compared, 0 = channel ignored.
- clear_err  input  1  one-cycle pulse; clears the sticky error state.
- data_c  input  NUM_CH*WIDTH  behavioural outputs; channel i is [i*WIDTH +: WIDTH].
- data_e  input  NUM_CH*WIDTH  structural outputs; same packing as data_c.
- checks_ok  output  1  registered result of the last cycle's compare.
- err_sticky  output  1  set on the first mismatch, held until cleared.
- err_mask  output  NUM_CH  per-channel sticky mismatch flags.
- err_count  output  CNT_W  saturating count of mismatching cycles.
- first_ch  output  $clog2(NUM_CH) (min 1)  index of the first failing channel.
- first_time  output  TIME_W  cycle stamp of the first mismatch.
- state  output  2  FSM state, for debug.

Behaviour:
- Reset (reset=1 at a rising edge):
  - Outputs: checks_ok=1, err_sticky=0, err_mask=0, err_count=0, first_ch=0, first_time=0, state=IDLE.
  - The cycle counter is cleared to 0.
- Cycle counter: increments every non-reset cycle and wraps modulo 2^TIME_W.
- Per-channel compare:
  - neq[i] = ch_mask[i] & (data_c chunk i !== data_e chunk i).
  - The compare is 4-state: X/Z on either side counts as a mismatch.
  - any_neq = OR of neq.
- FSM states, encoded IDLE=0, ARM=1, CHECK=2, FAIL=3:
  - IDLE: compares ignored, checks_ok=1. Moves to ARM when check_en=1; the settle counter loads SETTLE_CYCLES.
  - ARM: compares ignored, settle counter decrements. Moves to CHECK when the counter is 0 on entry or reaches 0. With SETTLE_CYCLES=0, ARM lasts exactly 1 cycle.
  - CHECK: on any_neq, moves to FAIL. The same edge does all of the following:
    - err_sticky<=1
    - err_mask|=neq
    - first_ch<=lowest i with neq[i]=1
    - first_time<=cycle counter value of that cycle
    - err_count increments
    - $display of time, first_ch and both values, issued once
  - FAIL: on any_neq, err_mask|=neq and err_count increments. first_ch and first_time are frozen and nothing is printed.
  - From any non-IDLE state, check_en=0 returns to IDLE. Sticky state, counters and captures are held.
  - clear_err in FAIL: clears err_sticky, err_mask and the first_* captures, then returns to CHECK. err_count is not cleared; only reset clears it.
  - clear_err in any other state: clears the same fields and causes no transition.
- Output timing:
  - checks_ok <= !(any_neq) in CHECK/FAIL, and 1 otherwise. One-cycle latency: a mismatch sampled at edge N shows checks_ok=0 after edge N.
  - err_count saturates at 2^CNT_W-1 and never wraps.
- Simultaneous events (priority from highest to lowest): reset > check_en=0 > clear_err > mismatch update.
  - A mismatch in the same cycle as clear_err is dropped: no count and no capture. The next cycle is compared normally.
- Reset during FAIL or ARM: immediate return to IDLE with all reset values. No message is printed.
- ch_mask changes take effect in the same cycle. Masking a channel does not clear its err_mask bit.

Test Plan:
- Equal data through reset, then check_en=1, SETTLE_CYCLES=2 → ARM for 2 cycles, then CHECK. checks_ok=1 throughout, err_count=0.
- In CHECK, channel 3 differs (c=4'hA, e=4'hB) for one cycle at cycle 10 → checks_ok=0 for 1 cycle, err_mask=5'b01000, first_ch=3, first_time=10, err_count=1, exactly one $display.
- In FAIL, channels 1 and 4 differ for 3 cycles → err_mask=5'b11010, err_count=4, first_ch=3 and first_time=10 unchanged, no further prints.
- clear_err pulse together with a channel 0 mismatch → err_sticky=0, err_mask=0, count unchanged. The next cycle's channel 0 mismatch gives first_ch=0 and err_count+1.
- ch_mask=5'b11110 with channel 0 differing, or a mismatch during ARM → no error recorded. Channel 2 driven X → counted as a mismatch.
- CNT_W=3 with 10 mismatching cycles → err_count stops at 7. Assert reset mid-FAIL → all outputs return to reset values on the next edge.
